seg7_scan_display: RTL and testbench

//  Multiplexed 6-digit 7-segment driver for the digital clock (HH MM SS).

---
 rtl/seg7_scan_display_pkg.sv | 39 +++
 rtl/seg7_scan_display_bcd_to_seg7.sv | 27 ++
 rtl/seg7_scan_display.sv | 112 +++++++++++
 tb/tb_seg7_scan_display.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the clock's multiplexed 7-segment display.
// Digit positions and active-high a-g segment codes.
package seg7_scan_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] DIG_SEC_L  = 3'd0;
  localparam logic [2:0] DIG_SEC_H  = 3'd1;
  localparam logic [2:0] DIG_MIN_L  = 3'd2;
  localparam logic [2:0] DIG_MIN_H  = 3'd3;
  localparam logic [2:0] DIG_HOUR_L = 3'd4;
  localparam logic [2:0] DIG_HOUR_H = 3'd5;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  function automatic logic [2:0] next_digit(
    input logic [2:0] idx
  );
    return (idx == DIG_HOUR_H) ? DIG_SEC_L : idx + 3'd1;
  endfunction

endpackage

// File: rtl/seg7_scan_display_bcd_to_seg7.sv
// BCD nibble to active-high a-g segment pattern.
// Non-decimal nibbles render as a dash.
module bcd_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  always_comb begin
    pat = SEG_DASH;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Six-digit HH MM SS multiplexed 7-segment driver with
// per-pair blink for time setting.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 500,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       en,
  input  logic [7:0] sec,
  input  logic [7:0] min,
  input  logic [7:0] hour,
  input  logic [2:0] blink_mask,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW =
    (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_TICKS - 1);

  localparam logic [5:0] AN_IDLE =
    AN_ACT_LOW ? 6'h3F : 6'h00;
  localparam logic [6:0] SEG_IDLE =
    SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic DP_IDLE = SEG_ACT_LOW;

  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [2:0]    idx;
  logic          tick;

  logic [2:0] idx_nxt;
  logic [7:0] pair_bcd;
  logic [3:0] nib;
  logic [6:0] pat;
  logic       pair_blink;
  logic       blank;
  disp_t      disp_nxt;

  assign tick = (presc == PRE_MAX);

  bcd_to_seg7 u_dec (
    .nib (nib),
    .pat (pat)
  );

  // Output word is built for the digit that becomes current at this tick.
  always_comb begin
    idx_nxt    = next_digit(idx);
    pair_bcd   = sec;
    pair_blink = blink_mask[0];
    case (idx_nxt)
      DIG_MIN_L, DIG_MIN_H: begin
        pair_bcd   = min;
        pair_blink = blink_mask[1];
      end
      DIG_HOUR_L, DIG_HOUR_H: begin
        pair_bcd   = hour;
        pair_blink = blink_mask[2];
      end
      default: begin
        pair_bcd   = sec;
        pair_blink = blink_mask[0];
      end
    endcase
    nib   = idx_nxt[0] ? pair_bcd[7:4] : pair_bcd[3:0];
    blank = pair_blink & blink_phase;

    disp_nxt.an  = en ? (6'b000001 << idx_nxt) : 6'b000000;
    disp_nxt.seg = blank ? SEG_OFF : pat;
    disp_nxt.dp  = ~blank &
      ((idx_nxt == DIG_MIN_L) | (idx_nxt == DIG_HOUR_L));
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      presc       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      idx         <= DIG_HOUR_H;
      an          <= AN_IDLE;
      seg         <= SEG_IDLE;
      dp          <= DP_IDLE;
    end else if (tick) begin
      presc <= '0;
      idx   <= idx_nxt;
      if (blink_cnt == BLK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      an  <= AN_ACT_LOW ? ~disp_nxt.an : disp_nxt.an;
      seg <= SEG_ACT_LOW ? ~disp_nxt.seg : disp_nxt.seg;
      dp  <= SEG_ACT_LOW ? ~disp_nxt.dp : disp_nxt.dp;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: directed steps plus random
// inputs checked against a tick-count reference model.
module tb_seg7_scan_display;

  localparam int SD = 4;
  localparam int BT = 3;

  logic       clk = 1'b0;
  logic       cr = 1'b1;
  logic       en = 1'b0;
  logic [7:0] sec = 8'h00;
  logic [7:0] min = 8'h00;
  logic [7:0] hour = 8'h00;
  logic [2:0] blink_mask = 3'b000;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad = 0;

  int n = 0;
  logic [5:0] exp_an = 6'h3F;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp = 1'b1;
  logic       seg_chk = 1'b1;
  logic [6:0] tbl [16];

  seg7_scan_display #(
    .SCAN_DIV    (SD),
    .BLINK_TICKS (BT),
    .SEG_ACT_LOW (1'b1),
    .AN_ACT_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .cr         (cr),
    .en         (en),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  // Model: the k-th tick after reset shows digit (k-1)%6,
  // blink phase flips every BT ticks.
  task automatic model_edge();
    int k, d, ph;
    logic [7:0] b;
    logic [3:0] nb;
    logic blank;
    if (cr) begin
      n = 0;
      exp_an = 6'h3F;
      exp_seg = 7'h7F;
      exp_dp = 1'b1;
      seg_chk = 1'b1;
    end else begin
      n++;
      if (n % SD == 0) begin
        k = n / SD;
        d = (k - 1) % 6;
        ph = ((k - 1) / BT) % 2;
        b = (d / 2 == 0) ? sec : (d / 2 == 1) ? min : hour;
        nb = (d % 2 == 1) ? b[7:4] : b[3:0];
        blank = blink_mask[d / 2] && (ph == 1);
        exp_an = en ? ~(6'd1 << d) : 6'h3F;
        exp_seg = blank ? 7'h7F : ~tbl[nb];
        exp_dp = blank ? 1'b1 : !(d == 2 || d == 4);
        seg_chk = en;
      end
    end
  endtask

  task automatic step();
    logic oh;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    total++;
    assert (an === exp_an) else begin
      bad++;
      $error("FAIL an: observed=%b expected=%b n=%0d",
             an, exp_an, n);
    end
    if (seg_chk) begin
      total++;
      assert (seg === exp_seg) else begin
        bad++;
        $error("FAIL seg: observed=%h expected=%h n=%0d",
               seg, exp_seg, n);
      end
      total++;
      assert (dp === exp_dp) else begin
        bad++;
        $error("FAIL dp: observed=%b expected=%b n=%0d",
               dp, exp_dp, n);
      end
    end
    oh = ($countones(~an) <= 1);
    total++;
    assert (oh === 1'b1) else begin
      bad++;
      $error("FAIL onehot: observed=%b expected=at_most_one_low",
             an);
    end
  endtask

  task automatic steps(input int c);
    for (int i = 0; i < c; i++) step();
  endtask

  task automatic chk(input string tag,
                     input logic [13:0] obs,
                     input logic [13:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, req);
    end
  endtask

  initial begin
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
            7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
            7'h40, 7'h40, 7'h40, 7'h40};

    // reset and first digit latency
    steps(2);
    chk("reset", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
    cr = 1'b0;
    en = 1'b1;
    hour = 8'h12;
    min = 8'h34;
    sec = 8'h56;
    steps(3);
    chk("pre_first", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
    step();
    chk("first_digit", {an, seg, dp},
        {6'b111110, 7'h02, 1'b1});
    steps(5 * SD);
    chk("hour_tens", {an, seg, dp},
        {6'b011111, 7'h79, 1'b1});
    steps(SD * 6);

    // invalid BCD shows dash
    sec = 8'h5A;
    steps(SD * 7);

    // blink on minutes pair
    sec = 8'h56;
    blink_mask = 3'b010;
    steps(SD * 24);
    blink_mask = 3'b000;

    // disable at digit 3 then resume
    while (an !== 6'b110111 && n < 5000) step();
    chk("at_digit3", {8'h00, an}, {8'h00, 6'b110111});
    en = 1'b0;
    steps(SD * 5);
    chk("disabled", {8'h00, an}, {8'h00, 6'h3F});
    en = 1'b1;
    steps(SD * 3);

    // mid-scan reset
    steps(SD);
    steps(2);
    cr = 1'b1;
    step();
    chk("mid_reset", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
    cr = 1'b0;
    blink_mask = 3'b111;
    steps(SD);
    chk("after_mid_reset", {8'h00, an}, {8'h00, 6'b111110});
    steps(SD * 12);

    // randomized stretch
    for (int i = 0; i < 3000; i++) begin
      if (i % 17 == 0) begin
        sec = 8'($urandom);
        min = 8'($urandom);
        hour = 8'($urandom);
      end
      if ($urandom_range(0, 99) < 4) en = ~en;
      if ($urandom_range(0, 99) < 5)
        blink_mask = 3'($urandom);
      cr = ($urandom_range(0, 299) == 0);
      step();
    end
    cr = 1'b0;
    en = 1'b1;
    steps(SD * 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
